// File: rtl/vx_sched_state_checker.sv
// Shadow model of the warp scheduler's per-warp active/stalled/thread-mask state.
// New mismatches against the DUT are stamped and queued in a first-word-fall-through error FIFO.
module vx_sched_state_checker #(
    parameter int                  NUM_WARPS   = 4,
    parameter int                  NUM_THREADS = 4,
    parameter int                  PC_BITS     = 30,
    parameter int                  ERR_DEPTH   = 4,
    parameter logic [PC_BITS-1:0]  STARTUP_PC  = '0,
    localparam int                 WID_W       = $clog2(NUM_WARPS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             compare_en,
    input  logic                             wspawn_valid,
    input  logic [NUM_WARPS-1:0]             wspawn_mask,
    input  logic [PC_BITS-1:0]               wspawn_pc,
    input  logic                             tmc_valid,
    input  logic [WID_W-1:0]                 tmc_wid,
    input  logic [NUM_THREADS-1:0]           tmc_mask,
    input  logic                             stall_set_valid,
    input  logic [WID_W-1:0]                 stall_set_wid,
    input  logic                             warp_ctl_valid,
    input  logic [WID_W-1:0]                 warp_ctl_wid,
    input  logic [NUM_WARPS-1:0]             dut_active_warps,
    input  logic [NUM_WARPS-1:0]             dut_stalled_warps,
    input  logic [NUM_WARPS*NUM_THREADS-1:0] dut_thread_masks,
    output logic [NUM_WARPS*PC_BITS-1:0]     shadow_pcs,
    output logic                             err_valid,
    input  logic                             err_ready,
    output logic [1:0]                       err_kind,
    output logic [WID_W-1:0]                 err_wid,
    output logic                             err_multi,
    output logic [31:0]                      err_cycle,
    output logic                             err_overflow,
    output logic [15:0]                      drop_cnt
);

    localparam int                     PTR_W    = $clog2(ERR_DEPTH);
    localparam int                     CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]       DEPTH_C  = CNT_W'(ERR_DEPTH);
    localparam logic [PTR_W-1:0]       PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_WARPS-1:0]   WARP0    = NUM_WARPS'(1);
    localparam logic [NUM_THREADS-1:0] THREAD0  = NUM_THREADS'(1);

    typedef enum logic [1:0] {
        KIND_ACTIVE = 2'd0,
        KIND_STALL  = 2'd1,
        KIND_TMASK  = 2'd2
    } err_kind_e;

    typedef struct packed {
        err_kind_e         kind;
        logic [WID_W-1:0]  wid;
        logic              multi;
        logic [31:0]       cycle;
    } err_rec_t;

    logic [NUM_WARPS-1:0]   active_q, active_d;
    logic [NUM_WARPS-1:0]   stalled_q, stalled_d;
    logic [NUM_THREADS-1:0] mask_q [NUM_WARPS];
    logic [NUM_THREADS-1:0] mask_d [NUM_WARPS];
    logic [PC_BITS-1:0]     pc_q   [NUM_WARPS];
    logic [PC_BITS-1:0]     pc_d   [NUM_WARPS];
    logic [NUM_THREADS-1:0] dut_mask [NUM_WARPS];

    logic [NUM_WARPS-1:0]   mis_active, mis_stall, mis_tmask;
    logic [NUM_WARPS-1:0]   prev_active_q, prev_stall_q, prev_tmask_q;
    logic [NUM_WARPS-1:0]   new_active, new_stall, new_tmask;
    logic [NUM_WARPS-1:0]   sel;
    logic                   push, push_ok, pop, full, drop;
    err_rec_t               rec, head;

    err_rec_t               mem_q [ERR_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   overflow_q;
    logic [15:0]            drop_cnt_q;
    logic [31:0]            cycle_q;

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_flat
        assign dut_mask[g]                       = dut_thread_masks[g*NUM_THREADS +: NUM_THREADS];
        assign shadow_pcs[g*PC_BITS +: PC_BITS]  = pc_q[g];
    end

    function automatic logic [WID_W-1:0] lowest_set(input logic [NUM_WARPS-1:0] v);
        lowest_set = '0;
        for (int w = NUM_WARPS - 1; w >= 0; w--) begin
            if (v[w]) lowest_set = w[WID_W-1:0];
        end
    endfunction

    // Event application order matters: each later step overrides the earlier ones on the same warp.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (latch).
        active_d  = active_q;
        stalled_d = stalled_q;
        mask_d    = mask_q;
        pc_d      = pc_q;
        if (wspawn_valid) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (wspawn_mask[w]) begin
                    active_d[w] = 1'b1;
                    pc_d[w]     = wspawn_pc;
                    mask_d[w]   = THREAD0;
                end
            end
        end
        if (tmc_valid) begin
            mask_d[tmc_wid] = tmc_mask;
            if (tmc_mask == '0) active_d[tmc_wid] = 1'b0;
        end
        if (warp_ctl_valid)  stalled_d[warp_ctl_wid]  = 1'b0;
        if (stall_set_valid) stalled_d[stall_set_wid] = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            active_q  <= WARP0;
            stalled_q <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                mask_q[w] <= (w == 0) ? THREAD0 : '0;
                pc_q[w]   <= (w == 0) ? STARTUP_PC : '0;
            end
        end else begin
            active_q  <= active_d;
            stalled_q <= stalled_d;
            mask_q    <= mask_d;
            pc_q      <= pc_d;
        end
    end

    // Thread masks of inactive warps are don't-care in the DUT.
    always_comb begin
        mis_active = active_q ^ dut_active_warps;
        mis_stall  = stalled_q ^ dut_stalled_warps;
        mis_tmask  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            mis_tmask[w] = active_q[w] && (mask_q[w] != dut_mask[w]);
        end
    end

    assign new_active = mis_active & ~prev_active_q;
    assign new_stall  = mis_stall  & ~prev_stall_q;
    assign new_tmask  = mis_tmask  & ~prev_tmask_q;

    always_comb begin
        push     = 1'b0;
        sel      = '0;
        rec      = '0;
        rec.kind = KIND_ACTIVE;
        if (compare_en) begin
            if (new_active != '0) begin
                push     = 1'b1;
                sel      = new_active;
                rec.kind = KIND_ACTIVE;
            end else if (new_stall != '0) begin
                push     = 1'b1;
                sel      = new_stall;
                rec.kind = KIND_STALL;
            end else if (new_tmask != '0) begin
                push     = 1'b1;
                sel      = new_tmask;
                rec.kind = KIND_TMASK;
            end
        end
        rec.wid   = lowest_set(sel);
        rec.multi = (sel & (sel - WARP0)) != '0;
        rec.cycle = cycle_q;
    end

    assign full    = (count_q == DEPTH_C);
    assign pop     = err_valid && err_ready;
    assign push_ok = push && !reset && (!full || pop);
    assign drop    = push && !reset && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
            cycle_q       <= '0;
            prev_active_q <= '0;
            prev_stall_q  <= '0;
            prev_tmask_q  <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (compare_en) begin
                prev_active_q <= mis_active;
                prev_stall_q  <= mis_stall;
                prev_tmask_q  <= mis_tmask;
            end else begin
                prev_active_q <= '0;
                prev_stall_q  <= '0;
                prev_tmask_q  <= '0;
            end
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= rec;
    end

    assign head         = mem_q[rd_ptr_q];
    assign err_valid    = (count_q != '0);
    assign err_kind     = head.kind;
    assign err_wid      = head.wid;
    assign err_multi    = head.multi;
    assign err_cycle    = head.cycle;
    assign err_overflow = overflow_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: doc/vx_sched_state_checker.md
# vx_sched_state_checker

Bench-side, synthesizable checker for the warp scheduler, parametrised in warp count, thread count, PC width and error-buffer depth. It decodes warp-control events (wspawn, tmc, stall set/clear), maintains a shadow copy of the per-warp active, stalled and thread-mask state, and compares that copy against the DUT state every cycle. Mismatches become timestamped error records in a ready/valid FIFO that the testbench drains. It sits beside the scheduler and is driven from the scheduler's testbench interface signals.

## Interface
- NUM_WARPS, 4, warp count, ≥2
- NUM_THREADS, 4, threads per warp, ≥1
- PC_BITS, 30, PC width
- ERR_DEPTH, 4, error FIFO entries, power of 2, ≥2
- STARTUP_PC, 0, PC of warp 0 after reset
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- compare_en  in  1  enables comparison; shadow updates regardless
- wspawn_valid  in  1  wspawn event
- wspawn_mask  in  NUM_WARPS  warps to spawn
- wspawn_pc  in  PC_BITS  start PC for spawned warps
- tmc_valid  in  1  thread-mask-control event
- tmc_wid  in  clog2(NUM_WARPS)  target warp
- tmc_mask  in  NUM_THREADS  new thread mask
- stall_set_valid / stall_set_wid  in  1 / clog2(NUM_WARPS)  warp stalled at issue
- warp_ctl_valid / warp_ctl_wid  in  1 / clog2(NUM_WARPS)  warp-control result; unstalls the warp
- dut_active_warps  in  NUM_WARPS  DUT active vector
- dut_stalled_warps  in  NUM_WARPS  DUT stalled vector
- dut_thread_masks  in  NUM_WARPS*NUM_THREADS  DUT masks, warp w at bits [w*NUM_THREADS +: NUM_THREADS]
- shadow_pcs  out  NUM_WARPS*PC_BITS  shadow start PCs
- err_valid  out  1  FIFO head valid
- err_ready  in  1  consumer pop
- err_kind  out  2  0=ACTIVE, 1=STALL, 2=TMASK
- err_wid  out  clog2(NUM_WARPS)  lowest mismatching warp
- err_multi  out  1  more than one warp mismatched in that kind
- err_cycle  out  32  cycle stamp of the record
- err_overflow  out  1  sticky; a record was dropped
- drop_cnt  out  16  dropped records, saturating

## Operation
- Reset values:
  - shadow active = 1 for warp 0 only; stalled = 0.
  - Thread mask of warp 0 = thread 0 only; all other masks = 0.
  - pc[0] = STARTUP_PC; all other PCs = 0.
  - FIFO empty; err_valid=0, err_overflow=0, drop_cnt=0, cycle counter=0, previous-mismatch vectors=0.
- Shadow update order within one cycle; later steps override earlier ones:
  - 1. wspawn: for each w in wspawn_mask, active[w]=1, pc[w]=wspawn_pc, mask[w]=thread-0 one-hot.
  - 2. tmc: mask[tmc_wid]=tmc_mask; if tmc_mask==0, active[tmc_wid]=0. tmc overrides wspawn on the same warp.
  - 3. warp_ctl: stalled[warp_ctl_wid]=0.
  - 4. stall_set: stalled[stall_set_wid]=1. Set wins over clear on the same warp.
- Comparison:
  - Per-warp mismatch vectors are computed each cycle between the registered shadow and the dut_* inputs, using state after the same clock edge.
  - TMASK compares masks only for warps that are shadow-active.
  - A record is generated only on a new mismatch: a bit that is set now but was clear in the previous cycle. Persistent mismatches are not re-reported.
  - At most one record per cycle. Kind priority is ACTIVE > STALL > TMASK.
  - err_wid is the lowest warp with a new mismatch in the chosen kind. err_multi=1 if that kind has ≥2 new bits. New mismatches of lower-priority kinds in the same cycle are dropped silently, not counted.
  - When compare_en=0, no records are generated and the previous-mismatch vectors are cleared to 0.
- Error FIFO:
  - Push when full and no pop in that cycle: the record is dropped, err_overflow set, drop_cnt += 1, saturating at 0xFFFF.
  - Push and pop in the same cycle when full: both succeed.
- Cycle counter: 32-bit, increments every non-reset cycle, wraps 0xFFFFFFFF→0.

## Timing
- Shadow state updates on the clock edge after an event.
- Mismatch detected in cycle N → err_valid high from cycle N+1 if the FIFO was empty; err_cycle = counter value in cycle N.
- FIFO is first-word-fall-through; pop occurs on err_valid && err_ready.
- Reset mid-operation flushes the FIFO and shadow in one cycle; no record is produced in the reset cycle.

## Test plan
- Reset release, DUT held at active=0001, stalled=0000, mask[0]=0001 → err_valid stays 0 for 100 cycles; shadow_pcs[0]=STARTUP_PC.
- wspawn_mask=1110, pc=0x100; DUT mirrors one cycle later → no errors, pc[1..3]=0x100. DUT active left at 0001 → one record {ACTIVE, wid=1, multi=1}; no further records while the mismatch persists.
- tmc and wspawn on warp 2 in the same cycle with tmc_mask=0 → shadow active[2]=0, mask[2]=0.
- stall_set and warp_ctl on warp 1 in the same cycle → shadow stalled[1]=1.
- err_ready=0; force 6 distinct new mismatches with ERR_DEPTH=4 → 4 records held, err_overflow=1, drop_cnt=2. A full FIFO with push and pop in the same cycle → drop_cnt unchanged.
- Assert reset while the FIFO holds 3 records → err_valid=0 next cycle; err_overflow=0, drop_cnt=0.
